// File: rtl/bt656_pkg.sv
// Constants and types shared by the BT.656 capture and output stages.
// Protection-bit checking of the TRS XY byte is enabled by BT656_PROT_CHECK_EN.
package bt656_pkg;

    localparam logic [10:0] LINE_BYTES = 11'd1440;
    localparam logic [9:0]  LINE_WORDS = 10'd720;
    localparam logic [8:0]  MAX_LINES  = 9'd288;
    localparam logic [19:0] FIELD_BASE = 20'h40000;

    localparam int XY_F  = 6;
    localparam int XY_V  = 5;
    localparam int XY_H  = 4;
    localparam int XY_P3 = 3;
    localparam int XY_P2 = 2;
    localparam int XY_P1 = 1;
    localparam int XY_P0 = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WAIT_SAV,
        ST_ACTIVE,
        ST_HOLD
    } cap_state_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_FF,
        M_00,
        M_0000
    } trs_state_e;

    // Word address of pixel pair idx on a line of a field.
    function automatic logic [19:0] word_addr(
        input logic       f,
        input logic [8:0] line,
        input logic [9:0] idx
    );
        logic [19:0] base;
        base = f ? FIELD_BASE : 20'd0;
        return base + ({11'd0, line} * {10'd0, LINE_WORDS}) + {10'd0, idx};
    endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// BT.656 timing reference (FF,00,00,XY) detector with optional XY protection
// check, compiled in when BT656_PROT_CHECK_EN is defined.
module bt656_trs_detect
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] td_q,
    output logic       trs_valid,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       prot_err,
    output logic       seq_err,
    output logic       esc
);

    trs_state_e st_q, st_d;
    logic       xy_seen;
    logic       prot_ok;

    assign xy_seen = (st_q == M_0000);
    assign f       = td_q[XY_F];
    assign v       = td_q[XY_V];
    assign h       = td_q[XY_H];

`ifdef BT656_PROT_CHECK_EN
    assign prot_ok = (td_q[XY_P3] == (v ^ h))
                  && (td_q[XY_P2] == (f ^ h))
                  && (td_q[XY_P1] == (f ^ v))
                  && (td_q[XY_P0] == (f ^ v ^ h));
    assign prot_err = xy_seen && !prot_ok;
`else
    assign prot_ok  = 1'b1;
    assign prot_err = 1'b0;
`endif

    assign trs_valid = xy_seen && prot_ok;
    assign seq_err   = ((st_q == M_FF) || (st_q == M_00)) && (td_q != 8'h00);
    // Preamble and XY bytes must never be taken as pixel data.
    assign esc       = (st_q != M_IDLE) || (td_q == 8'hFF);

    always_comb begin
        st_d = (td_q == 8'hFF) ? M_FF : M_IDLE;
        unique case (st_q)
            M_FF:    if (td_q == 8'h00) st_d = M_00;
            M_00:    if (td_q == 8'h00) st_d = M_0000;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= M_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

endmodule

// File: rtl/bt656_sram_capture.sv
// BT.656 capture: decodes SAA7113 stream and packs active lines into frame SRAM.
// Define BT656_PROT_CHECK_EN to reject TRS codes with bad XY protection bits.
module bt656_sram_capture
    import bt656_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  td,
    input  logic        config_done,
    input  logic        capture_en,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        field,
    output logic [8:0]  line_cnt,
    output logic        frame_done,
    output logic        error
);

    logic [7:0]  td_q;
    cap_state_e  state_q;
    logic [10:0] k_q;
    logic [7:0]  lo_q;
    logic        field_q;
    logic [8:0]  line_q;
    logic        vseen_q;
    logic [19:0] addr_q;
    logic [15:0] data_q;
    logic        ce_n_q;
    logic        we_n_q;
    logic        frame_done_q;
    logic        error_q;

    logic        trs_valid, trs_f, trs_v, trs_h;
    logic        prot_err, seq_err, esc;
    logic [19:0] addr_d;
    logic [8:0]  line_d;
    logic        take_d;

    bt656_trs_detect u_trs (
        .clk       (clk),
        .rst       (rst),
        .td_q      (td_q),
        .trs_valid (trs_valid),
        .f         (trs_f),
        .v         (trs_v),
        .h         (trs_h),
        .prot_err  (prot_err),
        .seq_err   (seq_err),
        .esc       (esc)
    );

    assign addr_d = word_addr(field_q, line_q, k_q[10:1]);
    assign line_d = (line_q < MAX_LINES) ? line_q + 9'd1 : line_q;
    assign take_d = !esc && (k_q < LINE_BYTES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            td_q <= '0;
        end else begin
            td_q <= td;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            lo_q         <= '0;
            field_q      <= 1'b0;
            line_q       <= '0;
            vseen_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else if (!config_done) begin
            state_q      <= ST_IDLE;
            vseen_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            if (seq_err || prot_err) error_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_SYNC;
                    vseen_q <= 1'b0;
                end
                ST_SYNC: begin
                    if (trs_valid && trs_v) begin
                        vseen_q <= 1'b1;
                    end else if (trs_valid && vseen_q && !trs_f && !trs_h) begin
                        state_q <= ST_ACTIVE;
                        ce_n_q  <= 1'b0;
                        field_q <= 1'b0;
                        line_q  <= '0;
                        k_q     <= '0;
                    end
                end
                ST_ACTIVE: begin
                    ce_n_q <= 1'b0;
                    if (trs_valid && trs_h) begin
                        state_q <= ST_WAIT_SAV;
                        ce_n_q  <= 1'b1;
                    end else if (take_d) begin
                        k_q <= k_q + 11'd1;
                        if (!k_q[0]) begin
                            lo_q <= td_q;
                        end else if (line_q < MAX_LINES) begin
                            we_n_q <= 1'b0;
                            data_q <= {td_q, lo_q};
                            addr_q <= addr_d;
                        end
                    end
                end
                ST_WAIT_SAV: begin
                    if (trs_valid && trs_v && field_q) begin
                        frame_done_q <= 1'b1;
                        vseen_q      <= 1'b0;
                        state_q      <= capture_en ? ST_SYNC : ST_HOLD;
                    end else if (trs_valid && !trs_v && !trs_h) begin
                        state_q <= ST_ACTIVE;
                        ce_n_q  <= 1'b0;
                        k_q     <= '0;
                        if (trs_f == field_q) begin
                            line_q <= line_d;
                        end else begin
                            field_q <= trs_f;
                            line_q  <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (capture_en) begin
                        state_q <= ST_SYNC;
                        vseen_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sram_addr  = addr_q;
    assign sram_data  = data_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = 1'b1;
    assign field      = field_q;
    assign line_cnt   = line_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_bt656_sram_capture.sv
// Directed bench for bt656_sram_capture: line table plus hand-written sequences.
// Expectations follow BT656_PROT_CHECK_EN when it is defined.
module tb_bt656_sram_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  td;
    logic        config_done;
    logic        capture_en;
    logic [19:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        field;
    logic [8:0]  line_cnt;
    logic        frame_done;
    logic        error;

    bt656_sram_capture dut (
        .clk         (clk),
        .rst         (rst),
        .td          (td),
        .config_done (config_done),
        .capture_en  (capture_en),
        .sram_addr   (sram_addr),
        .sram_data   (sram_data),
        .sram_ce_n   (sram_ce_n),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .field       (field),
        .line_cnt    (line_cnt),
        .frame_done  (frame_done),
        .error       (error)
    );

    always #5 clk = ~clk;

`ifdef BT656_PROT_CHECK_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic        f;
        int          nbytes;
        logic        exp_field;
        int          exp_line;
        int          exp_writes;
        logic [19:0] exp_first;
    } lvec_t;

    wr_t   wq[$];
    lvec_t tbl[9];
    int    total = 0;
    int    bad = 0;
    int    fd_cnt = 0;
    int    consec = 0;
    logic  prev_we_low = 1'b0;

    always @(negedge clk) begin
        wr_t w;
        if (sram_we_n === 1'b0) begin
            w.addr = sram_addr;
            w.data = sram_data;
            wq.push_back(w);
            if (prev_we_low) consec++;
        end
        prev_we_low = (sram_we_n === 1'b0);
        if (frame_done === 1'b1) fd_cnt++;
    end

    function automatic logic [7:0] pix(input int i);
        return 8'h10 + 8'((i * 16) % 224);
    endfunction

    function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic [7:0] b);
        @(negedge clk);
        td = b;
    endtask

    task automatic fill(input int n);
        repeat (n) tick(8'h10);
    endtask

    task automatic trs(input logic [7:0] x);
        tick(8'hFF);
        tick(8'h00);
        tick(8'h00);
        tick(x);
    endtask

    task automatic send_line(input logic f, input int n);
        trs(xy(f, 1'b0, 1'b0));
        for (int i = 0; i < n; i++) tick(pix(i));
        trs(xy(f, 1'b0, 1'b1));
        fill(2);
    endtask

    task automatic chk_writes(input string nm, input int n, input logic [19:0] first);
        int errs;
        logic [19:0] la;
        errs = 0;
        chk({nm, " count"}, 32'(wq.size()), 32'(n));
        for (int j = 0; j < wq.size() && j < n; j++) begin
            if (wq[j].addr !== first + 20'(j) ||
                wq[j].data !== {pix(2 * j + 1), pix(2 * j)}) errs++;
        end
        chk({nm, " words"}, 32'(errs), 32'd0);
        if (n > 0) begin
            la = (wq.size() > 0) ? wq[wq.size() - 1].addr : 20'hFFFFF;
            chk({nm, " last addr"}, 32'(la), 32'(first + 20'(n - 1)));
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " addr"}, 32'(sram_addr), 32'd0);
        chk({nm, " data"}, 32'(sram_data), 32'd0);
        chk({nm, " ce_n"}, 32'(sram_ce_n), 32'd1);
        chk({nm, " we_n"}, 32'(sram_we_n), 32'd1);
        chk({nm, " oe_n"}, 32'(sram_oe_n), 32'd1);
        chk({nm, " field"}, 32'(field), 32'd0);
        chk({nm, " line"}, 32'(line_cnt), 32'd0);
        chk({nm, " frame_done"}, 32'(frame_done), 32'd0);
        chk({nm, " error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] la;
        tbl[0] = '{1'b0, 1440, 1'b0, 0, 720, 20'h00000};
        tbl[1] = '{1'b0, 100,  1'b0, 1, 50,  20'h002D0};
        tbl[2] = '{1'b0, 1446, 1'b0, 2, 720, 20'h005A0};
        tbl[3] = '{1'b1, 8,    1'b1, 0, 4,   20'h40000};
        tbl[4] = '{1'b1, 8,    1'b1, 1, 4,   20'h402D0};
        tbl[5] = '{1'b1, 8,    1'b1, 2, 4,   20'h405A0};
        tbl[6] = '{1'b1, 8,    1'b1, 3, 4,   20'h40870};
        tbl[7] = '{1'b1, 8,    1'b1, 4, 4,   20'h40B40};
        tbl[8] = '{1'b1, 8,    1'b1, 5, 4,   20'h40E10};

        rst = 1'b0;
        td = 8'h10;
        config_done = 1'b0;
        capture_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        fill(2);
        config_done = 1'b1;
        capture_en = 1'b1;
        fill(2);
        chk("sync ce_n", 32'(sram_ce_n), 32'd1);

        trs(xy(1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 9; i++) begin
            wq.delete();
            send_line(tbl[i].f, tbl[i].nbytes);
            chk_writes($sformatf("line%0d", i), tbl[i].exp_writes, tbl[i].exp_first);
            chk($sformatf("line%0d field", i), 32'(field), 32'(tbl[i].exp_field));
            chk($sformatf("line%0d line_cnt", i), 32'(line_cnt), 32'(tbl[i].exp_line));
            chk($sformatf("line%0d ce_n", i), 32'(sram_ce_n), 32'd1);
        end

        // XY 0x85: F=V=H=0 with corrupted protection bits
        wq.delete();
        trs(8'h85);
        for (int i = 0; i < 4; i++) tick(pix(i));
        trs(xy(1'b0, 1'b0, 1'b1));
        fill(2);
        chk_writes("prot", PROT ? 0 : 2, 20'h00000);
        chk("prot field", 32'(field), PROT ? 32'd1 : 32'd0);
        chk("prot line", 32'(line_cnt), PROT ? 32'd5 : 32'd0);
        chk("prot error", 32'(error), PROT ? 32'd1 : 32'd0);

        tick(8'hFF);
        tick(8'h00);
        tick(8'h12);
        fill(2);
        chk("seq error", 32'(error), 32'd1);
        chk("seq line", 32'(line_cnt), PROT ? 32'd5 : 32'd0);
        chk("seq ce_n", 32'(sram_ce_n), 32'd1);
        wq.delete();
        send_line(PROT, 4);
        chk_writes("after err", 2, PROT ? 20'h410E0 : 20'h002D0);
        chk("after err line", 32'(line_cnt), PROT ? 32'd6 : 32'd1);

        config_done = 1'b0;
        fill(2);
        chk("cfg low error", 32'(error), 32'd0);
        chk("cfg low ce_n", 32'(sram_ce_n), 32'd1);
        config_done = 1'b1;
        fill(2);

        trs(xy(1'b0, 1'b1, 1'b0));
        send_line(1'b0, 4);
        send_line(1'b1, 4);
        capture_en = 1'b0;
        send_line(1'b1, 4);
        chk("f1 field", 32'(field), 32'd1);
        chk("f1 line", 32'(line_cnt), 32'd1);
        trs(xy(1'b1, 1'b1, 1'b0));
        @(negedge clk);
        chk("fd early", 32'(frame_done), 32'd0);
        td = 8'h10;
        @(negedge clk);
        chk("fd pulse", 32'(frame_done), 32'd1);
        td = 8'h10;
        @(negedge clk);
        chk("fd width", 32'(frame_done), 32'd0);
        td = 8'h10;

        wq.delete();
        trs(xy(1'b0, 1'b1, 1'b0));
        send_line(1'b0, 4);
        chk("hold writes", 32'(wq.size()), 32'd0);
        chk("hold ce_n", 32'(sram_ce_n), 32'd1);
        capture_en = 1'b1;
        fill(2);
        send_line(1'b0, 4);
        chk("sync no v writes", 32'(wq.size()), 32'd0);
        wq.delete();
        trs(xy(1'b0, 1'b1, 1'b0));
        send_line(1'b0, 4);
        chk_writes("restart", 2, 20'h00000);
        chk("restart field", 32'(field), 32'd0);
        chk("restart line", 32'(line_cnt), 32'd0);

        wq.delete();
        for (int i = 1; i <= 289; i++) send_line(1'b0, 2);
        chk("sat writes", 32'(wq.size()), 32'd287);
        chk("sat line", 32'(line_cnt), 32'd288);
        la = (wq.size() > 0) ? wq[wq.size() - 1].addr : 20'hFFFFF;
        chk("sat last addr", 32'(la), 32'h32730);

        wq.delete();
        trs(xy(1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) tick(pix(i));
        @(negedge clk);
        chk("active ce_n", 32'(sram_ce_n), 32'd0);
        rst = 1'b0;
        #1;
        chk_reset("mid reset");
        fill(3);
        chk("partial write", 32'(wq.size()), 32'd2);

        chk("frame_done count", 32'(fd_cnt), 32'd1);
        chk("we_n spacing", 32'(consec), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
